decode_stage: RTL
=================

# decode_stage

RV32I instruction decode stage between the fetch stage and the execute stage. It splits each accepted instruction into fields and drives the register file read addresses combinationally. It captures the returned operands, the immediate and the control fields into a one-entry ID/EX register. A 31-bit busy scoreboard, fed by the writeback port, stalls any instruction that reads or overwrites a register whose write is still in flight.

## Interface
- No parameters (XLEN fixed at 32, 32 architectural registers).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid / if_ready  in / out  1  fetch handshake
- if_instr, if_pc  in  32  instruction word and its PC
- rf_raddr_rs1, rf_raddr_rs2  out  5  register file read addresses, equal to if_instr[19:15] / [24:20]
- rf_rdata_rs1, rf_rdata_rs2  in  32  combinational read data; x0 already reads as 0
- wb_we, wb_rd, wb_data  in  1/5/32  writeback notification; the same signals drive the register file write port
- flush  in  1  kill younger work (branch/jump redirect from execute)
- ex_valid / ex_ready  out / in  1  execute handshake
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  32  captured PC, operands and sign-extended immediate
- ex_rd  out  5  destination register
- ex_rd_we  out  1  the instruction writes ex_rd (0 when rd = x0)
- ex_opcode  out  7  opcode field
- ex_funct3  out  3  funct3 field
- ex_funct7b5  out  1  instr[30]
- ex_illegal  out  1  opcode not in RV32I

## Operation
- Decode of if_instr is purely combinational.
  - uses_rs1 is set for every opcode except LUI, AUIPC, JAL.
  - uses_rs2 is set for OP, STORE, BRANCH.
  - rd_we is set for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, with rd != 0.
- Immediate is built per format, sign-extended from instr[31]:
  - I: LOAD, OP-IMM, JALR
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - All other opcodes produce 0.
- Illegal opcode:
  - ex_illegal=1, ex_rd_we=0, ex_imm=0.
  - The instruction still passes through so execute can trap.
- Scoreboard busy[31:1]:
  - Cleared when wb_we && wb_rd != 0.
  - Set on accept when rd_we.
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is constant 0.
- hazard = (uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]) || (rd_we && busy[rd]). Source and destination checks ignore x0.
- if_ready = (!ex_valid || ex_ready) && !hazard && !flush.
- Accept (if_valid && if_ready):
  - Loads the ID/EX register from decode and rf_rdata.
  - Sets ex_valid=1.
- Consume (ex_valid && ex_ready) with no accept: ex_valid=0. Fields keep their values.
- flush=1:
  - No accept.
  - If ex_valid && !ex_ready, the held entry is killed: ex_valid=0, and busy[ex_rd] is cleared if ex_rd_we.
  - An entry consumed in the same cycle proceeds normally.
- Operand values are not updated while an entry is held under ex_ready=0. This is safe because the scoreboard guarantees its sources are stable.

## Timing
- Reset, asynchronous, sets:
  - ex_valid=0
  - all ex_* fields = 0
  - busy = 0
- if_ready is combinational from state and inputs.
- Latency: an instruction accepted at edge N appears on ex_* after edge N, i.e. 1 cycle.
- Throughput: 1 instruction/cycle with no hazards and ex_ready=1.
- Register file writes at the edge where wb_we is sampled. Without bypass, a dependent instruction stalls through that cycle and is accepted the next cycle.
- Reset deasserted mid-stall: no state survives; fetch must re-present its instruction.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - A source register being written this cycle (wb_we && wb_rd == rs != 0) is not treated as busy in hazard, unless it is also being set.
  - The captured operand is taken from wb_data instead of rf_rdata.
  - The dependent instruction is accepted in the same cycle as the writeback.
- Undefined:
  - No bypass mux.
  - The dependent instruction is accepted one cycle after the writeback.

## Test plan
- **Reset:**
  - Stimulus: hold rst_n=0 with if_valid=1.
  - Required response: ex_valid=0, all ex_* fields 0, if_ready=1 after release.
- **Immediates:**
  - Stimulus: instructions 0xFFF00093 (addi x1,x0,-1), 0xFE20AE23 (sw x2,-4(x1)), 0x00001537 (lui x10,1).
  - Required response: ex_imm = 0xFFFFFFFF, 0xFFFFFFFC, 0x00001000; ex_rd_we = 1, 0, 1.
- **RAW stall:**
  - Stimulus: addi x5 accepted; next add x6,x5,x5 presented.
  - Required response: if_ready=0 until wb_we=1 with wb_rd=5 and wb_data=0x2A.
    - Bypass: accepted that cycle with ex_rs1_val = ex_rs2_val = 0x2A.
    - No bypass: accepted one cycle later with the same values.
- **Backpressure:**
  - Stimulus: ex_ready=0 for 3 cycles with the entry held.
  - Required response: ex_* stable, if_ready=0; the next instruction is accepted in the cycle ex_ready returns to 1.
- **Flush:**
  - Stimulus: entry writing x7 held with ex_ready=0; flush=1.
  - Required response: ex_valid=0 next cycle, busy[7] cleared; a following reader of x7 is accepted without waiting for writeback.
- **Illegal / x0:**
  - Stimulus: opcode 0x7F instruction; separately, addi x0,x0,1.
  - Required response: ex_illegal=1 with ex_rd_we=0; the x0 instruction sets no busy bit and causes no stall.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: field split, immediate build, busy scoreboard and one-entry ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data into the captured operands.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic [4:0]  rf_raddr_rs1,
  output logic [4:0]  rf_raddr_rs2,
  input  logic [31:0] rf_rdata_rs1,
  input  logic [31:0] rf_rdata_rs2,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_rd_we,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,
  output logic        ex_illegal
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic        legal, uses_rs1, uses_rs2, writes_rd, rd_we;
  imm_fmt_e    imm_fmt;
  logic [31:0] imm;
  logic [31:0] busy_q, busy_d;
  logic        rs1_busy, rs2_busy, hazard, accept, kill;
  logic [31:0] op1, op2;

  assign opcode       = if_instr[6:0];
  assign rd           = if_instr[11:7];
  assign rs1          = if_instr[19:15];
  assign rs2          = if_instr[24:20];
  assign rf_raddr_rs1 = rs1;
  assign rf_raddr_rs2 = rs2;

  always_comb begin
    legal     = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    imm_fmt   = ImmNone;
    case (opcode)
      OpLui, OpAuipc:        begin writes_rd = 1'b1; imm_fmt = ImmU; end
      OpJal:                 begin writes_rd = 1'b1; imm_fmt = ImmJ; end
      OpJalr, OpLoad, OpImm: begin writes_rd = 1'b1; imm_fmt = ImmI; end
      OpOp:                  begin writes_rd = 1'b1; uses_rs2 = 1'b1; end
      OpStore:               begin uses_rs2 = 1'b1; imm_fmt = ImmS; end
      OpBranch:              begin uses_rs2 = 1'b1; imm_fmt = ImmB; end
      OpFence, OpSystem:     ;
      default:               legal = 1'b0;
    endcase
  end

  assign uses_rs1 = (opcode != OpLui) && (opcode != OpAuipc) && (opcode != OpJal);
  assign rd_we    = writes_rd && (rd != 5'd0);

  always_comb begin
    imm = '0;
    case (imm_fmt)
      ImmI:    imm = {{20{if_instr[31]}}, if_instr[31:20]};
      ImmS:    imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      ImmB:    imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                      if_instr[11:8], 1'b0};
      ImmU:    imm = {if_instr[31:12], 12'h000};
      ImmJ:    imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                      if_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

`ifdef DECODE_WB_BYPASS_EN
  logic wb_hit_rs1, wb_hit_rs2;
  assign wb_hit_rs1 = wb_we && (wb_rd == rs1) && (rs1 != 5'd0);
  assign wb_hit_rs2 = wb_we && (wb_rd == rs2) && (rs2 != 5'd0);
  assign rs1_busy   = busy_q[rs1] && !wb_hit_rs1;
  assign rs2_busy   = busy_q[rs2] && !wb_hit_rs2;
  assign op1        = wb_hit_rs1 ? wb_data : rf_rdata_rs1;
  assign op2        = wb_hit_rs2 ? wb_data : rf_rdata_rs2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign rs1_busy       = busy_q[rs1];
  assign rs2_busy       = busy_q[rs2];
  assign op1            = rf_rdata_rs1;
  assign op2            = rf_rdata_rs2;
`endif

  // busy_q[0] is held at zero, so x0 never contributes to a hazard.
  assign hazard   = (uses_rs1 && rs1_busy) || (uses_rs2 && rs2_busy) || (rd_we && busy_q[rd]);
  assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;
  assign kill     = flush && ex_valid && !ex_ready;

  // Priority: set on accept beats any clear in the same cycle.
  always_comb begin
    busy_d = busy_q;
    if (wb_we) busy_d[wb_rd] = 1'b0;
    if (kill && ex_rd_we) busy_d[ex_rd] = 1'b0;
    if (accept && rd_we) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_rd_we    <= 1'b0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_illegal  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        ex_valid    <= 1'b1;
        ex_pc       <= if_pc;
        ex_rs1_val  <= op1;
        ex_rs2_val  <= op2;
        ex_imm      <= imm;
        ex_rd       <= rd;
        ex_rd_we    <= rd_we;
        ex_opcode   <= opcode;
        ex_funct3   <= if_instr[14:12];
        ex_funct7b5 <= if_instr[30];
        ex_illegal  <= !legal;
      end else if (ex_ready || flush) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule
